memreader: RTL and testbench
============================

MEMREADER -- requirements
Module: memreader

Interface
REQ-001 Parameter RD_SIGNATURE, default 16'h5AA5, high word of a read command; byte 2 = 8'hA5, byte 3 = 8'h5A.
REQ-002 Parameter ADDR_W, default 25, width of the memory word address.
REQ-003 mem_clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-005 sr_data_rdy  in  1  one-cycle strobe: sr_data holds a received serial byte.
REQ-006 sr_data  in  8  byte from the serial receiver.
REQ-007 mem_idle  in  1  memory controller can accept a request this cycle.
REQ-008 mem_ack  in  1  controller accepted the pending read request.
REQ-009 mem_rd_data_valid  in  1  one-cycle strobe: mem_rd_data holds the requested word.
REQ-010 mem_rd_data  in  32  read word.
REQ-011 mem_rd_addr  out  ADDR_W  word address of the current read.
REQ-012 mem_rd_req  out  1  read request, held until mem_ack.
REQ-013 tx_busy  in  1  serial transmitter is busy.
REQ-014 tx_start  out  1  one-cycle pulse: tx_data shall be transmitted.
REQ-015 tx_data  out  8  byte to transmit.
REQ-016 busy  out  1  high in every state except HUNT.

Function
REQ-017 States: HUNT, ADDR, WAIT_WND, RD_REQ, RD_DATA, TX_BYTE, TX_WAIT.
REQ-018 HUNT: each sr_data_rdy byte shifts into a 32-bit window (newest byte into bits 31:24); on match of bits 31:16 with RD_SIGNATURE, latch len = bits 15:0 (b0 low, b1 high) and go to ADDR next cycle.
REQ-019 ADDR: collect exactly 4 bytes, little-endian, into a 32-bit addr; after the 4th byte, go to HUNT if len==0 or addr[31]==1, else go to WAIT_WND.
REQ-020 mem_rd_addr = addr[ADDR_W-1:0] at all times.
REQ-021 WAIT_WND: go to RD_REQ when mem_idle==1.
REQ-022 RD_REQ: mem_rd_req=1 from the first RD_REQ cycle; cleared on the cycle after mem_ack; state goes to RD_DATA on mem_ack.
REQ-023 RD_DATA: on mem_rd_data_valid, capture mem_rd_data into a word register, clear the byte index to 0, go to TX_BYTE.
REQ-024 TX_BYTE: when tx_busy==0, drive tx_data = word byte[index] (index 0 = bits 7:0, LSB first), pulse tx_start for exactly one cycle, go to TX_WAIT.
REQ-025 TX_WAIT: ignore tx_busy in the first cycle; thereafter, when tx_busy==0, either increment index and return to TX_BYTE (index<3), or finish the word (index==3).
REQ-026 Word finish: increment addr by 1 (wrap modulo 2^32) and the word counter; go to HUNT if the counter equals len, else go to WAIT_WND.
REQ-027 The word counter is 16 bits and is cleared in ADDR; len=16'hFFFF shall transfer 65535 words.
REQ-028 sr_data_rdy bytes arriving outside HUNT/ADDR are dropped; the HUNT window is cleared on entry to HUNT.
REQ-029 mem_data_valid arriving outside RD_DATA is ignored.
REQ-030 tx_data holds its value between tx_start pulses.

Reset
REQ-031 reset==0 forces immediately: state=HUNT, mem_rd_req=0, tx_start=0, tx_data=0, busy=0, addr=0, len=0, window=0, counters=0, index=0.
REQ-032 Reset mid-transfer abandons the transfer; after release, the block hunts for a fresh command and issues no residual request.

Structure
REQ-033 Shared package memrw_pkg holds the write and read command signatures and the memreader state encodings.
REQ-034 Single module with no sub-modules; a separate word-to-byte serializer shall not be created.

Verification
REQ-035 Bytes 02 00 A5 5A 10 00 00 00, memory[16]=0x44332211, memory[17]=0x88776655 -> reads at addresses 16 and 17; tx bytes 11 22 33 44 55 66 77 88; then HUNT, busy=0.
REQ-036 Noise bytes 00 A5 then 01 00 A5 5A 00 00 00 00 -> exactly one command detected, 1 word read at address 0.
REQ-037 len=0 command, then address bytes -> no mem_rd_req, no tx_start, returns to HUNT.
REQ-038 Address 0x80000010 with len=3 -> no reads, returns to HUNT.
REQ-039 tx_busy held high 50 cycles after each tx_start -> exactly one tx_start per byte, 4 per word, no lost or duplicated byte.
REQ-040 reset pulsed low during the 2nd byte of word 1 -> mem_rd_req=0 and tx_start=0 immediately; a following valid command executes normally.

Source files
------------

// File: rtl/memrw_pkg.sv
// Shared definitions for the memory read/write command blocks: command signatures and
// the memreader state encoding.
package memrw_pkg;

  // High word of a command; low byte arrives first on the serial link.
  localparam logic [15:0] WR_CMD_SIG = 16'hA55A;
  localparam logic [15:0] RD_CMD_SIG = 16'h5AA5;

  localparam int unsigned CMD_W = 32;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    StHunt    = 3'd0,
    StAddr    = 3'd1,
    StWaitWnd = 3'd2,
    StRdReq   = 3'd3,
    StRdData  = 3'd4,
    StTxByte  = 3'd5,
    StTxWait  = 3'd6
  } rd_state_e;

endpackage

// File: rtl/memreader.sv
// Serial-commanded memory reader: hunts for a read command, fetches len words from memory
// and streams each word out LSB byte first through the serial transmitter.
module memreader
  import memrw_pkg::*;
#(
  parameter logic [15:0] RD_SIGNATURE = RD_CMD_SIG,
  parameter int unsigned ADDR_W       = 25
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              sr_data_rdy,
  input  logic [7:0]        sr_data,
  input  logic              mem_idle,
  input  logic              mem_ack,
  input  logic              mem_rd_data_valid,
  input  logic [31:0]       mem_rd_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_req,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy
);

  rd_state_e          state_q, state_d;
  logic [CMD_W-1:0]   window_q, window_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic [1:0]         abyte_q, abyte_d;
  logic [1:0]         idx_q, idx_d;
  logic [31:0]        word_q, word_d;
  logic               first_q, first_d;
  logic               req_q, req_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic [CMD_W-1:0]   window_shift;
  logic [31:0]        addr_shift;
  logic [LEN_W-1:0]   wcnt_inc;

  assign window_shift = {sr_data, window_q[CMD_W-1:8]};
  assign addr_shift   = {sr_data, addr_q[31:8]};
  assign wcnt_inc     = wcnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    abyte_d    = abyte_q;
    idx_d      = idx_q;
    word_d     = word_q;
    first_d    = 1'b0;
    req_d      = req_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      StHunt: begin
        if (sr_data_rdy) begin
          window_d = window_shift;
          if (window_shift[31:16] == RD_SIGNATURE) begin
            len_d   = window_shift[15:0];
            state_d = StAddr;
          end
        end
      end

      StAddr: begin
        wcnt_d = '0;
        if (sr_data_rdy) begin
          // Little-endian: each new byte enters at the top, the first ends up in bits 7:0.
          addr_d  = addr_shift;
          abyte_d = abyte_q + 2'd1;
          if (abyte_q == 2'd3) begin
            state_d = (len_q == '0 || addr_shift[31]) ? StHunt : StWaitWnd;
          end
        end
      end

      StWaitWnd: begin
        if (mem_idle) begin
          req_d   = 1'b1;
          state_d = StRdReq;
        end
      end

      StRdReq: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = StRdData;
        end
      end

      StRdData: begin
        if (mem_rd_data_valid) begin
          word_d  = mem_rd_data;
          idx_d   = 2'd0;
          state_d = StTxByte;
        end
      end

      StTxByte: begin
        if (!tx_busy) begin
          tx_data_d  = word_q[{idx_q, 3'b000} +: 8];
          tx_start_d = 1'b1;
          first_d    = 1'b1;
          state_d    = StTxWait;
        end
      end

      StTxWait: begin
        // The transmitter may not raise busy until it has seen the start pulse.
        if (!first_q && !tx_busy) begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = StTxByte;
          end else begin
            addr_d  = addr_q + 32'd1;
            wcnt_d  = wcnt_inc;
            state_d = (wcnt_inc == len_q) ? StHunt : StWaitWnd;
          end
        end
      end

      default: state_d = StHunt;
    endcase

    // A fresh hunt never matches on bytes left over from the previous command.
    if (state_d == StHunt && state_q != StHunt) begin
      window_d = '0;
    end
  end

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StHunt;
      window_q   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wcnt_q     <= '0;
      abyte_q    <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      first_q    <= 1'b0;
      req_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      abyte_q    <= abyte_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      first_q    <= first_d;
      req_q      <= req_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign mem_rd_addr = addr_q[ADDR_W-1:0];
  assign mem_rd_req  = req_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != StHunt);

endmodule

// File: tb/tb_memreader.sv
// Bench for memreader: drives serial command bytes, models the memory controller and the
// serial transmitter, and compares reads and transmitted bytes against expected queues.
module tb_memreader;
  import memrw_pkg::*;

  localparam int unsigned ADDR_W = 25;

  logic              mem_clk = 1'b0;
  logic              reset = 1'b0;
  logic              sr_data_rdy = 1'b0;
  logic [7:0]        sr_data = 8'h00;
  logic              mem_idle;
  logic              mem_ack;
  logic              mem_rd_data_valid;
  logic [31:0]       mem_rd_data;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_req;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;

  memreader #(
    .RD_SIGNATURE(RD_CMD_SIG),
    .ADDR_W(ADDR_W)
  ) dut (
    .mem_clk(mem_clk),
    .reset(reset),
    .sr_data_rdy(sr_data_rdy),
    .sr_data(sr_data),
    .mem_idle(mem_idle),
    .mem_ack(mem_ack),
    .mem_rd_data_valid(mem_rd_data_valid),
    .mem_rd_data(mem_rd_data),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_req(mem_rd_req),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .busy(busy)
  );

  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int failures = 0;

  // Observed traffic, appended by the models; tests compare from a recorded base index.
  logic [ADDR_W-1:0] rd_addrs[$];
  logic [7:0]        tx_bytes[$];
  logic [ADDR_W-1:0] exp_addrs[$];
  logic [7:0]        exp_bytes[$];

  int   tx_hold_lo = 1;
  int   tx_hold_hi = 3;
  int   idle_pct = 70;
  bit   spur_en = 1'b1;
  int   dup_err = 0;
  int   hold_err = 0;
  int   req_err = 0;
  int   req_rises = 0;

  int   tx_cnt = 0;
  bit   tx_pend = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0] last_tx = 8'h00;

  int   ctl_phase = 0;
  int   ctl_wait = 0;
  logic ctl_prev_req = 1'b0;
  logic [ADDR_W-1:0] ctl_addr = '0;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 25'd16) return 32'h44332211;
    if (a == 25'd17) return 32'h88776655;
    return {a[7:0] ^ 8'h5C, a[15:8] + 8'h3B, a[23:16] ^ 8'hE1, {7'd0, a[24]} + a[7:0]};
  endfunction

  // Reference: len words from addr upward, each sent LSB byte first; rejected commands do nothing.
  task automatic expect_cmd(input logic [15:0] len, input logic [31:0] addr);
    logic [31:0] a;
    logic [31:0] w;
    if (len == 16'd0 || addr[31]) return;
    for (int k = 0; k < int'(len); k++) begin
      a = addr + 32'(k);
      exp_addrs.push_back(a[ADDR_W-1:0]);
      w = mem_word(a[ADDR_W-1:0]);
      for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
    end
  endtask

  // Transmitter: busy rises one cycle after the start pulse and holds for a programmable time.
  initial begin : tx_model
    tx_busy = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (!reset) begin
        tx_busy = 1'b0;
        tx_pend = 1'b0;
        tx_cnt = 0;
        prev_start = 1'b0;
        last_tx = 8'h00;
        continue;
      end
      if (tx_start) begin
        if (prev_start || tx_busy || tx_pend) dup_err++;
        tx_bytes.push_back(tx_data);
        last_tx = tx_data;
      end else if (tx_data !== last_tx) begin
        hold_err++;
      end
      prev_start = tx_start;
      if (tx_pend) begin
        tx_busy = 1'b1;
        tx_pend = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_busy = 1'b0;
      end
      if (tx_start) begin
        tx_pend = 1'b1;
        tx_cnt = int'($urandom_range(tx_hold_hi, tx_hold_lo));
      end
    end
  end

  // Memory controller: acks a held request after a random delay, then returns the word.
  initial begin : mem_model
    mem_idle = 1'b1;
    mem_ack = 1'b0;
    mem_rd_data_valid = 1'b0;
    mem_rd_data = 32'h0;
    forever begin
      @(negedge mem_clk);
      mem_ack = 1'b0;
      mem_rd_data_valid = 1'b0;
      if (!reset) begin
        ctl_phase = 0;
        ctl_prev_req = 1'b0;
        mem_idle = 1'b1;
        continue;
      end
      if (mem_rd_req && !ctl_prev_req) begin
        req_rises++;
        if (!mem_idle) req_err++;
      end
      ctl_prev_req = mem_rd_req;
      case (ctl_phase)
        0: begin
          if (mem_rd_req) begin
            ctl_wait = int'($urandom_range(2, 0));
            ctl_phase = 1;
          end else if (spur_en && $urandom_range(3, 0) == 0) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data = $urandom;
          end
        end
        1: begin
          if (!mem_rd_req) req_err++;
          if (ctl_wait == 0) begin
            mem_ack = 1'b1;
            rd_addrs.push_back(mem_rd_addr);
            ctl_addr = mem_rd_addr;
            ctl_wait = int'($urandom_range(3, 0));
            ctl_phase = 2;
          end else begin
            ctl_wait--;
          end
        end
        default: begin
          if (mem_rd_req) req_err++;
          if (ctl_wait == 0) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data = mem_word(ctl_addr);
            ctl_phase = 0;
          end else begin
            ctl_wait--;
          end
        end
      endcase
      mem_idle = ($urandom_range(99, 0) < idle_pct);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    sr_data = b;
    sr_data_rdy = 1'b1;
    @(negedge mem_clk);
    sr_data_rdy = 1'b0;
    sr_data = 8'($urandom);
    repeat ($urandom_range(2, 0)) @(negedge mem_clk);
  endtask

  task automatic send_cmd(input logic [15:0] len, input logic [31:0] addr);
    logic [15:0] sig;
    sig = RD_CMD_SIG;
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    send_byte(sig[7:0]);
    send_byte(sig[15:8]);
    for (int b = 0; b < 4; b++) send_byte(addr[8*b +: 8]);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge mem_clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge mem_clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++;
    if (mem_rd_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b required 0", mem_rd_req); end
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_start: got %b required 0", tx_start); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_txdata: got %h required 00", tx_data); end
    checks++;
    if (mem_rd_addr !== '0) begin failures++; $display("FAIL rst_addr: got %h required 0", mem_rd_addr); end
    reset = 1'b1;
    repeat (4) @(negedge mem_clk);
    checks++;
    if (busy !== 1'b0 || req_rises != 0) begin
      failures++;
      $display("FAIL rst_release: busy=%b reqs=%0d required 0/0", busy, req_rises);
    end
  endtask

  task automatic test_basic;
    int rb, tb;
    bit ok;
    exp_addrs.delete();
    exp_bytes.delete();
    rb = rd_addrs.size();
    tb = tx_bytes.size();
    tx_hold_lo = 1;
    tx_hold_hi = 3;
    expect_cmd(16'd2, 32'd16);
    send_cmd(16'd2, 32'h0000_0010);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done: busy=%b required 0", busy); end
    checks++;
    if (rd_addrs.size() - rb != exp_addrs.size()) begin
      failures++;
      $display("FAIL basic_nreads: got %0d required %0d", rd_addrs.size() - rb, exp_addrs.size());
    end
    foreach (exp_addrs[i]) if (rb + i < rd_addrs.size()) begin
      checks++;
      if (rd_addrs[rb + i] !== exp_addrs[i]) begin
        failures++;
        $display("FAIL basic_addr%0d: got %h required %h", i, rd_addrs[rb + i], exp_addrs[i]);
      end
    end
    checks++;
    if (tx_bytes.size() - tb != exp_bytes.size()) begin
      failures++;
      $display("FAIL basic_nbytes: got %0d required %0d", tx_bytes.size() - tb, exp_bytes.size());
    end
    foreach (exp_bytes[i]) if (tb + i < tx_bytes.size()) begin
      checks++;
      if (tx_bytes[tb + i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL basic_byte%0d: got %h required %h", i, tx_bytes[tb + i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_noise;
    int rb, tb, r0;
    bit ok;
    logic [7:0] stream[$];
    exp_addrs.delete();
    exp_bytes.delete();
    rb = rd_addrs.size();
    tb = tx_bytes.size();
    r0 = req_rises;
    stream = '{8'h00, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    expect_cmd(16'd1, 32'd0);
    foreach (stream[i]) send_byte(stream[i]);
    wait_idle(ok);
    checks++;
    if (!ok || req_rises - r0 != 1) begin
      failures++;
      $display("FAIL noise_cmds: idle=%b reqs=%0d required 1/1", ok, req_rises - r0);
    end
    checks++;
    if (rd_addrs.size() - rb != 1 || rd_addrs[rb] !== exp_addrs[0]) begin
      failures++;
      $display("FAIL noise_read: got %0d reads required 1 at %h", rd_addrs.size() - rb, exp_addrs[0]);
    end
    checks++;
    if (tx_bytes.size() - tb != 4) begin
      failures++;
      $display("FAIL noise_nbytes: got %0d required 4", tx_bytes.size() - tb);
    end
    foreach (exp_bytes[i]) if (tb + i < tx_bytes.size()) begin
      checks++;
      if (tx_bytes[tb + i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL noise_byte%0d: got %h required %h", i, tx_bytes[tb + i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_len_zero;
    int tb, r0, rb;
    bit ok;
    logic [7:0] stream[$];
    tb = tx_bytes.size();
    r0 = req_rises;
    send_cmd(16'd0, 32'h0000_0030);
    repeat (3) @(negedge mem_clk);
    checks++;
    if (busy !== 1'b0 || req_rises != r0 || tx_bytes.size() != tb) begin
      failures++;
      $display("FAIL len0: busy=%b reqs=%0d bytes=%0d required 0/0/0", busy, req_rises - r0,
               tx_bytes.size() - tb);
    end
    // Window starts from zero after the command, so A5 5A alone forms a len=0 command.
    stream = '{8'hA5, 8'h5A, 8'h20, 8'h00, 8'h00, 8'h00};
    foreach (stream[i]) send_byte(stream[i]);
    repeat (3) @(negedge mem_clk);
    checks++;
    if (busy !== 1'b0 || req_rises != r0 || tx_bytes.size() != tb) begin
      failures++;
      $display("FAIL window_clear: busy=%b reqs=%0d bytes=%0d required 0/0/0", busy,
               req_rises - r0, tx_bytes.size() - tb);
    end
    rb = rd_addrs.size();
    send_cmd(16'd1, 32'd5);
    wait_idle(ok);
    checks++;
    if (!ok || rd_addrs.size() - rb != 1 || tx_bytes.size() - tb != 4) begin
      failures++;
      $display("FAIL after_len0: idle=%b reads=%0d bytes=%0d required 1/1/4", ok,
               rd_addrs.size() - rb, tx_bytes.size() - tb);
    end else begin
      checks++;
      if (rd_addrs[rb] !== 25'd5) begin
        failures++;
        $display("FAIL after_len0_addr: got %h required 5", rd_addrs[rb]);
      end
    end
  endtask

  task automatic test_addr_bit31;
    int tb, r0;
    send_cmd(16'd3, 32'h8000_0010);
    tb = tx_bytes.size();
    r0 = req_rises;
    repeat (10) @(negedge mem_clk);
    checks++;
    if (busy !== 1'b0 || req_rises != r0 || tx_bytes.size() != tb) begin
      failures++;
      $display("FAIL addr31: busy=%b reqs=%0d bytes=%0d required 0/0/0", busy, req_rises - r0,
               tx_bytes.size() - tb);
    end
  endtask

  task automatic test_slow_tx;
    int rb, tb, r0, e0;
    bit ok;
    logic [31:0] addr;
    exp_addrs.delete();
    exp_bytes.delete();
    rb = rd_addrs.size();
    tb = tx_bytes.size();
    r0 = req_rises;
    e0 = dup_err + hold_err + req_err;
    tx_hold_lo = 50;
    tx_hold_hi = 50;
    addr = {7'd0, 25'($urandom)};
    expect_cmd(16'd2, addr);
    send_cmd(16'd2, addr);
    for (int i = 0; i < 2000 && tx_bytes.size() == tb; i++) @(negedge mem_clk);
    // Sent while the word is being transmitted; must be dropped.
    send_cmd(16'd1, 32'h0000_0100);
    wait_idle(ok);
    checks++;
    if (!ok || req_rises - r0 != 2) begin
      failures++;
      $display("FAIL slow_reqs: idle=%b reqs=%0d required 1/2", ok, req_rises - r0);
    end
    checks++;
    if (dup_err + hold_err + req_err != e0) begin
      failures++;
      $display("FAIL slow_proto: got %0d protocol errors required 0", dup_err + hold_err + req_err - e0);
    end
    checks++;
    if (tx_bytes.size() - tb != exp_bytes.size()) begin
      failures++;
      $display("FAIL slow_nbytes: got %0d required %0d", tx_bytes.size() - tb, exp_bytes.size());
    end
    foreach (exp_bytes[i]) if (tb + i < tx_bytes.size()) begin
      checks++;
      if (tx_bytes[tb + i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL slow_byte%0d: got %h required %h", i, tx_bytes[tb + i], exp_bytes[i]);
      end
    end
    foreach (exp_addrs[i]) if (rb + i < rd_addrs.size()) begin
      checks++;
      if (rd_addrs[rb + i] !== exp_addrs[i]) begin
        failures++;
        $display("FAIL slow_addr%0d: got %h required %h", i, rd_addrs[rb + i], exp_addrs[i]);
      end
    end
    tx_hold_lo = 1;
    tx_hold_hi = 3;
  endtask

  task automatic test_reset_mid;
    int rb, tb, r0;
    bit ok;
    logic [31:0] addr;
    tb = tx_bytes.size();
    tx_hold_lo = 6;
    tx_hold_hi = 6;
    send_cmd(16'd2, {7'd0, 25'($urandom)});
    for (int i = 0; i < 2000 && tx_bytes.size() < tb + 2; i++) @(negedge mem_clk);
    checks++;
    if (tx_bytes.size() < tb + 2) begin
      failures++;
      $display("FAIL midrst_reach: got %0d bytes required 2", tx_bytes.size() - tb);
    end
    @(posedge mem_clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_rd_req !== 1'b0 || tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_outputs: req=%b start=%b busy=%b data=%h required 0/0/0/00",
               mem_rd_req, tx_start, busy, tx_data);
    end
    @(negedge mem_clk);
    @(negedge mem_clk);
    #2 reset = 1'b1;
    @(negedge mem_clk);
    r0 = req_rises;
    tb = tx_bytes.size();
    repeat (20) @(negedge mem_clk);
    checks++;
    if (busy !== 1'b0 || req_rises != r0 || tx_bytes.size() != tb) begin
      failures++;
      $display("FAIL midrst_residual: busy=%b reqs=%0d bytes=%0d required 0/0/0", busy,
               req_rises - r0, tx_bytes.size() - tb);
    end
    tx_hold_lo = 1;
    tx_hold_hi = 3;
    exp_addrs.delete();
    exp_bytes.delete();
    rb = rd_addrs.size();
    addr = {7'd0, 25'($urandom)};
    expect_cmd(16'd1, addr);
    send_cmd(16'd1, addr);
    wait_idle(ok);
    checks++;
    if (!ok || rd_addrs.size() - rb != 1 || tx_bytes.size() - tb != 4) begin
      failures++;
      $display("FAIL midrst_next: idle=%b reads=%0d bytes=%0d required 1/1/4", ok,
               rd_addrs.size() - rb, tx_bytes.size() - tb);
    end else begin
      checks++;
      if (rd_addrs[rb] !== exp_addrs[0]) begin
        failures++;
        $display("FAIL midrst_addr: got %h required %h", rd_addrs[rb], exp_addrs[0]);
      end
      foreach (exp_bytes[i]) begin
        checks++;
        if (tx_bytes[tb + i] !== exp_bytes[i]) begin
          failures++;
          $display("FAIL midrst_byte%0d: got %h required %h", i, tx_bytes[tb + i], exp_bytes[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    int rb, tb, e0;
    bit ok;
    logic [15:0] len;
    logic [31:0] addr;
    for (int n = 0; n < 8; n++) begin
      exp_addrs.delete();
      exp_bytes.delete();
      rb = rd_addrs.size();
      tb = tx_bytes.size();
      e0 = dup_err + hold_err + req_err;
      tx_hold_lo = 1;
      tx_hold_hi = int'($urandom_range(4, 1));
      idle_pct = int'($urandom_range(100, 30));
      len = 16'($urandom_range(4, 0));
      addr = {($urandom_range(7, 0) == 0), 31'($urandom)};
      repeat ($urandom_range(3, 0)) send_byte(8'($urandom_range(127, 0)));
      expect_cmd(len, addr);
      send_cmd(len, addr);
      wait_idle(ok);
      checks++;
      if (!ok || dup_err + hold_err + req_err != e0) begin
        failures++;
        $display("FAIL rnd%0d_proto: idle=%b errors=%0d required 1/0", n, ok,
                 dup_err + hold_err + req_err - e0);
      end
      checks++;
      if (rd_addrs.size() - rb != exp_addrs.size() || tx_bytes.size() - tb != exp_bytes.size()) begin
        failures++;
        $display("FAIL rnd%0d_counts: reads=%0d bytes=%0d required %0d/%0d", n,
                 rd_addrs.size() - rb, tx_bytes.size() - tb, exp_addrs.size(), exp_bytes.size());
      end
      foreach (exp_addrs[i]) if (rb + i < rd_addrs.size()) begin
        checks++;
        if (rd_addrs[rb + i] !== exp_addrs[i]) begin
          failures++;
          $display("FAIL rnd%0d_addr%0d: got %h required %h", n, i, rd_addrs[rb + i], exp_addrs[i]);
        end
      end
      foreach (exp_bytes[i]) if (tb + i < tx_bytes.size()) begin
        checks++;
        if (tx_bytes[tb + i] !== exp_bytes[i]) begin
          failures++;
          $display("FAIL rnd%0d_byte%0d: got %h required %h", n, i, tx_bytes[tb + i], exp_bytes[i]);
        end
      end
    end
    idle_pct = 70;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timed out");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_noise();
    test_len_zero();
    test_addr_bit31();
    test_slow_tx();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
